// File: rtl/frankie_pkg.sv
// Shared encodings and field positions for the Frankie CPU front end.
package frankie_pkg;

    localparam logic [2:0] PC_INC         = 3'b000;
    localparam logic [2:0] PC_SHELLEY     = 3'b001;
    localparam logic [2:0] PC_IMM         = 3'b010;
    localparam logic [2:0] PC_RA          = 3'b011;
    localparam logic [2:0] PC_MARY        = 3'b100;
    localparam logic [2:0] PC_SHELLEY2    = 3'b101;
    localparam logic [2:0] PC_CMP_IMM     = 3'b110;
    localparam logic [2:0] PC_CMP_SHELLEY = 3'b111;

    localparam logic RA_FROM_MEM = 1'b0;
    localparam logic RA_FROM_PC  = 1'b1;

    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 11;
    localparam int FLAG_BIT = 10;

endpackage

// File: rtl/frankie_next_pc.sv
// Next-PC selector: picks the new PC from PCSrc and qualifies the write with Comp.
module frankie_next_pc
    import frankie_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              pc_write_i,
    input  logic [2:0]        pc_src_i,
    input  logic              comp_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] ra_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [DATA_W-1:0] mary_i,
    input  logic [DATA_W-1:0] shelley_i,
    output logic [DATA_W-1:0] next_pc_o,
    output logic              pc_we_o,
    output logic              inst_addr_we_o
);

    always_comb begin
        next_pc_o      = pc_i;
        pc_we_o        = 1'b0;
        inst_addr_we_o = 1'b0;
        // PCSrc is only decoded under PCWrite, so an undriven select is harmless when idle
        if (pc_write_i) begin
            case (pc_src_i)
                PC_INC: begin
                    next_pc_o      = pc_i + DATA_W'(1);
                    pc_we_o        = 1'b1;
                    inst_addr_we_o = 1'b1;
                end
                PC_SHELLEY, PC_SHELLEY2: begin
                    next_pc_o = shelley_i;
                    pc_we_o   = 1'b1;
                end
                PC_IMM: begin
                    next_pc_o = imm_i;
                    pc_we_o   = 1'b1;
                end
                PC_RA: begin
                    next_pc_o = ra_i;
                    pc_we_o   = 1'b1;
                end
                PC_MARY: begin
                    next_pc_o = mary_i;
                    pc_we_o   = 1'b1;
                end
                PC_CMP_IMM: begin
                    next_pc_o = imm_i;
                    pc_we_o   = comp_i;
                end
                PC_CMP_SHELLEY: begin
                    next_pc_o = shelley_i;
                    pc_we_o   = comp_i;
                end
                default: begin
                    next_pc_o      = pc_i;
                    pc_we_o        = 1'b0;
                    inst_addr_we_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/frankie_fetch_unit.sv
// Frankie fetch stage: PC, InstAddr, IR, RA and Comp registers plus IR field split.
module frankie_fetch_unit
    import frankie_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                IMM_W    = 10,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              PCWrite,
    input  logic [2:0]        PCSrc,
    input  logic              InstWrite,
    input  logic              RAWrite,
    input  logic              RASrc,
    input  logic              CompWrite,
    input  logic [DATA_W-1:0] MemData,
    input  logic [DATA_W-1:0] AluResult,
    input  logic [DATA_W-1:0] Mary,
    input  logic [DATA_W-1:0] Shelley,
    output logic [DATA_W-1:0] InstAddr,
    output logic [DATA_W-1:0] PC,
    output logic [DATA_W-1:0] RA,
    output logic              Comp,
    output logic [4:0]        OPCODE,
    output logic              flagbit,
    output logic [DATA_W-1:0] Imm
);

    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] inst_addr_q;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] ra_q, ra_d;
    logic              comp_q;
    logic              pc_we;
    logic              inst_addr_we;
    logic [DATA_W-1:0] imm_ext;
    logic              unused_alu_hi;

    assign imm_ext       = {{(DATA_W-IMM_W){1'b0}}, ir_q[IMM_W-1:0]};
    assign unused_alu_hi = ^AluResult[DATA_W-1:1];

    frankie_next_pc #(
        .DATA_W(DATA_W)
    ) u_next_pc (
        .pc_write_i     (PCWrite),
        .pc_src_i       (PCSrc),
        .comp_i         (comp_q),
        .pc_i           (pc_q),
        .ra_i           (ra_q),
        .imm_i          (imm_ext),
        .mary_i         (Mary),
        .shelley_i      (Shelley),
        .next_pc_o      (pc_d),
        .pc_we_o        (pc_we),
        .inst_addr_we_o (inst_addr_we)
    );

    // Link value is the pre-edge PC, so a same-edge jump still records the caller
    assign ra_d = (RASrc == RA_FROM_PC) ? pc_q : MemData;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pc_q        <= RESET_PC;
            inst_addr_q <= RESET_PC;
            ir_q        <= '0;
            ra_q        <= '0;
            comp_q      <= 1'b0;
        end else begin
            if (pc_we) begin
                pc_q <= pc_d;
            end
            if (inst_addr_we) begin
                inst_addr_q <= pc_q;
            end
            if (InstWrite) begin
                ir_q <= MemData;
            end
            if (RAWrite) begin
                ra_q <= ra_d;
            end
            if (CompWrite) begin
                comp_q <= AluResult[0];
            end
        end
    end

    assign PC       = pc_q;
    assign InstAddr = inst_addr_q;
    assign RA       = ra_q;
    assign Comp     = comp_q;
    assign OPCODE   = ir_q[OP_MSB:OP_LSB];
    assign flagbit  = ir_q[FLAG_BIT];
    assign Imm      = imm_ext;

endmodule

// File: doc/frankie_fetch_unit.md
Name: frankie_fetch_unit

Overview:
- Front-end stage of the "Frankie" multicycle CPU, directly upstream of the control unit.
- Holds the program counter (PC), instruction address latch (InstAddr), instruction register (IR), return-address register (RA) and compare flag (Comp).
- Splits IR into OPCODE / flagbit / immediate, which feed the control unit.
- Applies the control unit's PCWrite/PCSrc, InstWrite, RAWrite/RASrc and CompWrite strobes.

Parameters:
- DATA_W, 16, width of the data path, PC, RA, IR and memory words
- IMM_W, 10, width of the immediate field IR[IMM_W-1:0]
- RESET_PC, 16'h0000, PC value after reset

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high reset
- PCWrite  in  1  PC update enable (from control unit)
- PCSrc  in  3  next-PC select
- InstWrite  in  1  load IR from MemData
- RAWrite  in  1  RA update enable
- RASrc  in  1  0: RA<=MemData, 1: RA<=PC
- CompWrite  in  1  Comp<=AluResult[0]
- MemData  in  DATA_W  memory read data
- AluResult  in  DATA_W  ALU output
- Mary  in  DATA_W  accumulator value
- Shelley  in  DATA_W  secondary register value
- InstAddr  out  DATA_W  address of the instruction being fetched
- PC  out  DATA_W  current program counter
- RA  out  DATA_W  return-address register
- Comp  out  1  compare flag
- OPCODE  out  5  IR[15:11]
- flagbit  out  1  IR[10]
- Imm  out  DATA_W  IR[9:0] zero-extended to DATA_W

Behaviour:
- Reset (async, active-high, any cycle, including mid-instruction):
  - PC<=RESET_PC, InstAddr<=RESET_PC, IR<=0, RA<=0, Comp<=0.
  - Outputs take these values immediately, without waiting for CLK.
  - Because IR<=0, OPCODE=0 and flagbit=0 during reset.
- PC update on the rising edge when PCWrite=1:
  - 000: PC<=PC+1 (word addressed, wraps 16'hFFFF->16'h0000), and InstAddr<=PC (old value) in the same edge.
  - 001: PC<=Shelley.
  - 010: PC<=Imm.
  - 011: PC<=RA.
  - 100: PC<=Mary.
  - 101: PC<=Shelley.
  - 110: PC<=Imm only if Comp=1; otherwise PC is held.
  - 111: PC<=Shelley only if Comp=1; otherwise PC is held.
- InstAddr changes only on PCWrite with PCSrc=000.
  - Memory reads the instruction at InstAddr during the Decode cycle, so IR receives the word at the pre-increment PC.
- IR<=MemData on the edge when InstWrite=1; otherwise held.
  - OPCODE, flagbit and Imm are combinational slices of IR, with zero added latency.
- RA<=(RASrc ? PC : MemData) when RAWrite=1.
  - Same-edge PCWrite: RA takes the old PC (the value before the edge). This is the jfnc link value.
- Comp<=AluResult[0] when CompWrite=1; otherwise held.
- Simultaneous events: all registers sample their pre-edge sources, with no internal forwarding.
  - PCSrc=011 with RAWrite=1: PC takes the old RA.
  - PCSrc 110/111 with CompWrite=1: the branch uses the old Comp.
- Unknown/X on PCSrc when PCWrite=0: no effect.
- No internal state machine. Sequencing belongs to the control unit. This block is a register file with a next-PC function.

Decomposition:
- Shared package frankie_pkg:
  - PCSrc encodings: PC_INC=3'b000, PC_SHELLEY=001, PC_IMM=010, PC_RA=011, PC_MARY=100, PC_SHELLEY2=101, PC_CMP_IMM=110, PC_CMP_SHELLEY=111.
  - RASrc encodings.
  - Opcode field positions (OP_MSB=15, OP_LSB=11, FLAG_BIT=10).
- One natural sub-module: frankie_next_pc, a combinational selector over PCSrc, Comp and the sources that outputs next-PC plus an effective write-enable.

Test Plan:
- Async reset: after running, assert Reset between clock edges. PC, InstAddr, RA and Comp read 0 before the next edge, and OPCODE=0.
- Sequential fetch from PC=5:
  - PCWrite=1, PCSrc=000, then InstWrite=1 with MemData=16'h4C07.
  - Result: InstAddr=5, PC=6, OPCODE=5'b01001, flagbit=1, Imm=7.
- PC wrap: PC=16'hFFFF, PCSrc=000 -> PC=0, InstAddr=16'hFFFF.
- Conditional jump:
  - Comp=0, PCSrc=110, Imm=16'h0020 -> PC unchanged.
  - Then CompWrite with AluResult=1 and retry -> PC=16'h0020.
  - CompWrite and PCSrc=110 on the same edge with Comp=0 -> no jump.
- Call/return: PC=16'h0010, RAWrite=1, RASrc=1, PCWrite, PCSrc=010, Imm=16'h0100.
  - Result: RA=16'h0010, PC=16'h0100.
  - Then PCSrc=011 -> PC=16'h0010.
- Register targets: Mary=16'h1234 with PCSrc=100 -> PC=16'h1234. Shelley=16'h0ABC with PCSrc=001 and with 101 -> PC=16'h0ABC.
